// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : pipe_ctrl_pkg
// Brief   : Shared hold encodings, bus widths and controller state encodings.
// Rev     : 1.0
//------------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int HOLDPIP_W   = 2;

   localparam logic [HOLDPIP_W-1:0] HOLD_NONE  = 2'b00;
   localparam logic [HOLDPIP_W-1:0] HOLD_WAIT  = 2'b01;
   localparam logic [HOLDPIP_W-1:0] HOLD_FLUSH = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_FLUSH2  = 2'd2
   } state_t;

   typedef struct packed {
      logic [HOLDPIP_W-1:0] pc;
      logic [HOLDPIP_W-1:0] if_id;
      logic [HOLDPIP_W-1:0] id_ex;
      logic [HOLDPIP_W-1:0] ex_mem;
      logic [HOLDPIP_W-1:0] mem_wb;
   } holds_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : pipe_ctrl
// Brief   : Five-stage pipeline hold/flush and PC-redirect controller.
//           Optional interrupt entry enabled by macro PIPE_CTRL_IRQ_EN.
// Rev     : 1.0
//------------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_wait_i,
   input  logic                   ex_stall_i,
   input  logic                   load_use_i,
   input  logic                   jump_req_i,
   input  logic [INST_ADDR_W-1:0] jump_addr_i,
`ifdef PIPE_CTRL_IRQ_EN
   input  logic                   irq_req_i,
   input  logic [INST_ADDR_W-1:0] mtvec_i,
   input  logic [INST_ADDR_W-1:0] ex_pc_i,
   output logic                   irq_ack_o,
   output logic [INST_ADDR_W-1:0] epc_o,
`endif
   output logic [HOLDPIP_W-1:0]   hold_pc_o,
   output logic [HOLDPIP_W-1:0]   hold_if_id_o,
   output logic [HOLDPIP_W-1:0]   hold_id_ex_o,
   output logic [HOLDPIP_W-1:0]   hold_ex_mem_o,
   output logic [HOLDPIP_W-1:0]   hold_mem_wb_o,
   output logic                   jump_en_o,
   output logic [INST_ADDR_W-1:0] jump_addr_o
);

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_pend_valid;
   logic [INST_ADDR_W-1:0] r_pend_addr;
   holds_t                 w_holds;
   logic                   w_take_jump;
   logic                   w_jump_en;
   logic [INST_ADDR_W-1:0] w_jump_addr;
`ifdef PIPE_CTRL_IRQ_EN
   logic                   w_irq_take;
   logic [INST_ADDR_W-1:0] r_epc;
`endif

   always_comb begin
      w_holds.pc     = HOLD_NONE;
      w_holds.if_id  = HOLD_NONE;
      w_holds.id_ex  = HOLD_NONE;
      w_holds.ex_mem = HOLD_NONE;
      w_holds.mem_wb = HOLD_NONE;
      w_next         = r_state;
      w_take_jump    = 1'b0;
      w_jump_en      = 1'b0;
      w_jump_addr    = '0;
`ifdef PIPE_CTRL_IRQ_EN
      w_irq_take     = 1'b0;
`endif
      if (rst) begin
         w_holds.pc     = HOLD_FLUSH;
         w_holds.if_id  = HOLD_FLUSH;
         w_holds.id_ex  = HOLD_FLUSH;
         w_holds.ex_mem = HOLD_FLUSH;
         w_holds.mem_wb = HOLD_FLUSH;
         w_next         = ST_RUN;
      end else if (mem_wait_i) begin
         w_holds.pc     = HOLD_WAIT;
         w_holds.if_id  = HOLD_WAIT;
         w_holds.id_ex  = HOLD_WAIT;
         w_holds.ex_mem = HOLD_WAIT;
         w_holds.mem_wb = HOLD_FLUSH;
         // A stale fetch still awaits discard once the bus frees up.
         w_next = (r_state == ST_FLUSH2) ? ST_FLUSH2 : ST_MEMWAIT;
      end else if (jump_req_i || r_pend_valid) begin
         w_take_jump   = 1'b1;
         w_jump_en     = 1'b1;
         w_jump_addr   = jump_req_i ? jump_addr_i : r_pend_addr;
         w_holds.if_id = HOLD_FLUSH;
         w_holds.id_ex = HOLD_FLUSH;
         w_next        = ST_FLUSH2;
`ifdef PIPE_CTRL_IRQ_EN
      end else if (irq_req_i && (r_state == ST_RUN)) begin
         w_irq_take     = 1'b1;
         w_jump_en      = 1'b1;
         w_jump_addr    = mtvec_i;
         w_holds.if_id  = HOLD_FLUSH;
         w_holds.id_ex  = HOLD_FLUSH;
         w_holds.ex_mem = HOLD_FLUSH;
         w_next         = ST_FLUSH2;
`endif
      end else begin
         if (ex_stall_i) begin
            w_holds.pc     = HOLD_WAIT;
            w_holds.if_id  = HOLD_WAIT;
            w_holds.id_ex  = HOLD_WAIT;
            w_holds.ex_mem = HOLD_FLUSH;
         end else if (load_use_i) begin
            w_holds.pc    = HOLD_WAIT;
            w_holds.if_id = HOLD_WAIT;
            w_holds.id_ex = HOLD_FLUSH;
         end
         // The synchronous ROM still presents the pre-redirect instruction.
         if (r_state == ST_FLUSH2) begin
            w_holds.if_id = HOLD_FLUSH;
         end
         w_next = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_RUN;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
      end else begin
         r_state <= w_next;
         if (mem_wait_i && jump_req_i) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= jump_addr_i;
         end else if (w_take_jump) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

`ifdef PIPE_CTRL_IRQ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_epc <= '0;
      end else if (w_irq_take) begin
         r_epc <= ex_pc_i;
      end
   end

   assign irq_ack_o = w_irq_take;
   assign epc_o     = r_epc;
`endif

   assign hold_pc_o     = w_holds.pc;
   assign hold_if_id_o  = w_holds.if_id;
   assign hold_id_ex_o  = w_holds.id_ex;
   assign hold_ex_mem_o = w_holds.ex_mem;
   assign hold_mem_wb_o = w_holds.mem_wb;
   assign jump_en_o     = w_jump_en;
   assign jump_addr_o   = w_jump_addr;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_pipe_ctrl
// Brief   : Directed self-checking bench for pipe_ctrl with a reference model.
// Rev     : 1.0
//------------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam logic [1:0] N = 2'b00;
   localparam logic [1:0] W = 2'b01;
   localparam logic [1:0] F = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_wait_i, ex_stall_i, load_use_i, jump_req_i;
   logic [31:0] jump_addr_i;
   logic        irq_req_i;
   logic [31:0] mtvec_i, ex_pc_i;
   logic [1:0]  hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
`ifdef PIPE_CTRL_IRQ_EN
   logic        irq_ack_o;
   logic [31:0] epc_o;
`endif

   int errors = 0;
   int checks = 0;

   pipe_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .mem_wait_i    (mem_wait_i),
      .ex_stall_i    (ex_stall_i),
      .load_use_i    (load_use_i),
      .jump_req_i    (jump_req_i),
      .jump_addr_i   (jump_addr_i),
`ifdef PIPE_CTRL_IRQ_EN
      .irq_req_i     (irq_req_i),
      .mtvec_i       (mtvec_i),
      .ex_pc_i       (ex_pc_i),
      .irq_ack_o     (irq_ack_o),
      .epc_o         (epc_o),
`endif
      .hold_pc_o     (hold_pc_o),
      .hold_if_id_o  (hold_if_id_o),
      .hold_id_ex_o  (hold_id_ex_o),
      .hold_ex_mem_o (hold_ex_mem_o),
      .hold_mem_wb_o (hold_mem_wb_o),
      .jump_en_o     (jump_en_o),
      .jump_addr_o   (jump_addr_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a pending redirect, a "discard next fetch" flag and
   // whether the previous cycle was spent waiting on memory.
   bit          m_pend = 1'b0;
   logic [31:0] m_pend_addr = '0;
   bit          m_discard = 1'b0;
   bit          m_prev_mw = 1'b0;
   logic [31:0] m_epc = '0;

   function automatic bit m_jump();
      return !rst && !mem_wait_i && (jump_req_i || m_pend);
   endfunction

   function automatic bit m_irq();
      return !rst && !mem_wait_i && !m_jump() && irq_req_i && !m_discard && !m_prev_mw;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pend = 1'b0; m_discard = 1'b0; m_prev_mw = 1'b0; m_epc = '0;
      end else if (mem_wait_i) begin
         if (jump_req_i) begin
            m_pend = 1'b1; m_pend_addr = jump_addr_i;
         end
         m_prev_mw = 1'b1;
      end else if (m_jump()) begin
         m_pend = 1'b0; m_discard = 1'b1; m_prev_mw = 1'b0;
      end else if (m_irq()) begin
         m_epc = ex_pc_i; m_discard = 1'b1; m_prev_mw = 1'b0;
      end else begin
         m_discard = 1'b0; m_prev_mw = 1'b0;
      end
   end

   logic [1:0]  e_pc, e_ifid, e_idex, e_exmem, e_memwb;
   logic        e_jen, e_ack;
   logic [31:0] e_jaddr;

   always @(negedge clk) begin
      e_pc = N; e_ifid = N; e_idex = N; e_exmem = N; e_memwb = N;
      e_jen = 1'b0; e_jaddr = '0; e_ack = 1'b0;
      if (rst) begin
         e_pc = F; e_ifid = F; e_idex = F; e_exmem = F; e_memwb = F;
      end else if (mem_wait_i) begin
         e_pc = W; e_ifid = W; e_idex = W; e_exmem = W; e_memwb = F;
      end else if (m_jump()) begin
         e_jen = 1'b1; e_jaddr = jump_req_i ? jump_addr_i : m_pend_addr;
         e_ifid = F; e_idex = F;
      end else if (m_irq()) begin
         e_jen = 1'b1; e_jaddr = mtvec_i; e_ack = 1'b1;
         e_ifid = F; e_idex = F; e_exmem = F;
      end else begin
         if (ex_stall_i) begin
            e_pc = W; e_ifid = W; e_idex = W; e_exmem = F;
         end else if (load_use_i) begin
            e_pc = W; e_ifid = W; e_idex = F;
         end
         if (m_discard) e_ifid = F;
      end
      chk("model hold_pc",     {30'd0, hold_pc_o},     {30'd0, e_pc});
      chk("model hold_if_id",  {30'd0, hold_if_id_o},  {30'd0, e_ifid});
      chk("model hold_id_ex",  {30'd0, hold_id_ex_o},  {30'd0, e_idex});
      chk("model hold_ex_mem", {30'd0, hold_ex_mem_o}, {30'd0, e_exmem});
      chk("model hold_mem_wb", {30'd0, hold_mem_wb_o}, {30'd0, e_memwb});
      chk("model jump_en",     {31'd0, jump_en_o},     {31'd0, e_jen});
      if (rst || e_jen) chk("model jump_addr", jump_addr_o, e_jaddr);
`ifdef PIPE_CTRL_IRQ_EN
      chk("model irq_ack", {31'd0, irq_ack_o}, {31'd0, e_ack});
      chk("model epc",     epc_o, rst ? 32'd0 : m_epc);
`endif
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk({"lit ", name}, act, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_wait_i = 1'b0; ex_stall_i = 1'b0; load_use_i = 1'b0;
      jump_req_i = 1'b0; jump_addr_i = '0; irq_req_i = 1'b0; mtvec_i = '0; ex_pc_i = '0;
      @(negedge clk);
      lit("rst hold_pc", {30'd0, hold_pc_o}, {30'd0, F});
      lit("rst hold_mem_wb", {30'd0, hold_mem_wb_o}, {30'd0, F});
      lit("rst jump_en", {31'd0, jump_en_o}, 32'd0);
      lit("rst jump_addr", jump_addr_o, 32'd0);
      go(); go(); rst = 1'b0;
      @(negedge clk);
      lit("idle hold_pc", {30'd0, hold_pc_o}, {30'd0, N});

      // load-use bubble
      go(); load_use_i = 1'b1;
      @(negedge clk);
      lit("lu hold_pc", {30'd0, hold_pc_o}, {30'd0, W});
      lit("lu hold_if_id", {30'd0, hold_if_id_o}, {30'd0, W});
      lit("lu hold_id_ex", {30'd0, hold_id_ex_o}, {30'd0, F});
      go(); load_use_i = 1'b0;
      @(negedge clk);
      lit("lu after hold_id_ex", {30'd0, hold_id_ex_o}, {30'd0, N});

      // plain redirect
      go(); jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100;
      @(negedge clk);
      lit("jmp jump_en", {31'd0, jump_en_o}, 32'd1);
      lit("jmp jump_addr", jump_addr_o, 32'h100);
      lit("jmp hold_id_ex", {30'd0, hold_id_ex_o}, {30'd0, F});
      go(); jump_req_i = 1'b0;
      @(negedge clk);
      lit("jmp+1 hold_if_id", {30'd0, hold_if_id_o}, {30'd0, F});
      lit("jmp+1 hold_id_ex", {30'd0, hold_id_ex_o}, {30'd0, N});
      lit("jmp+1 jump_en", {31'd0, jump_en_o}, 32'd0);
      go();
      @(negedge clk);
      lit("jmp+2 hold_if_id", {30'd0, hold_if_id_o}, {30'd0, N});

      // jump deferred behind a memory wait
      go(); mem_wait_i = 1'b1;
      @(negedge clk);
      lit("mw1 hold_mem_wb", {30'd0, hold_mem_wb_o}, {30'd0, F});
      lit("mw1 hold_ex_mem", {30'd0, hold_ex_mem_o}, {30'd0, W});
      go(); jump_req_i = 1'b1; jump_addr_i = 32'h0000_0200;
      @(negedge clk);
      lit("mw2 jump_en", {31'd0, jump_en_o}, 32'd0);
      go(); jump_req_i = 1'b0;
      @(negedge clk);
      lit("mw3 hold_pc", {30'd0, hold_pc_o}, {30'd0, W});
      go(); mem_wait_i = 1'b0;
      @(negedge clk);
      lit("mw4 jump_en", {31'd0, jump_en_o}, 32'd1);
      lit("mw4 jump_addr", jump_addr_o, 32'h200);
      go(); go();

      // latest pending request overwrites the earlier one
      go(); mem_wait_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h300;
      go(); jump_addr_i = 32'h340;
      go(); mem_wait_i = 1'b0; jump_req_i = 1'b0;
      @(negedge clk);
      lit("ovr jump_addr", jump_addr_o, 32'h340);
      go(); go();

      // EX stall beats load-use; jump beats EX stall
      go(); ex_stall_i = 1'b1; load_use_i = 1'b1;
      @(negedge clk);
      lit("exs hold_ex_mem", {30'd0, hold_ex_mem_o}, {30'd0, F});
      lit("exs hold_id_ex", {30'd0, hold_id_ex_o}, {30'd0, W});
      go(); load_use_i = 1'b0; jump_req_i = 1'b1; jump_addr_i = 32'h400;
      @(negedge clk);
      lit("exs+jmp jump_en", {31'd0, jump_en_o}, 32'd1);
      lit("exs+jmp hold_ex_mem", {30'd0, hold_ex_mem_o}, {30'd0, N});
      go(); jump_req_i = 1'b0;
      go(); ex_stall_i = 1'b0;
      go();

      // reset in FLUSH2 with a pending jump discards it
      go(); jump_req_i = 1'b1; jump_addr_i = 32'h500;
      go(); mem_wait_i = 1'b1; jump_addr_i = 32'h600;
      @(negedge clk);
      lit("f2mw hold_if_id", {30'd0, hold_if_id_o}, {30'd0, W});
      go(); rst = 1'b1; mem_wait_i = 1'b0; jump_req_i = 1'b0;
      @(negedge clk);
      lit("rst2 hold_id_ex", {30'd0, hold_id_ex_o}, {30'd0, F});
      lit("rst2 jump_en", {31'd0, jump_en_o}, 32'd0);
      go(); rst = 1'b0;
      @(negedge clk);
      lit("post rst jump_en", {31'd0, jump_en_o}, 32'd0);
      go();
      @(negedge clk);
      lit("post rst+1 jump_en", {31'd0, jump_en_o}, 32'd0);

`ifdef PIPE_CTRL_IRQ_EN
      go(); irq_req_i = 1'b1; mtvec_i = 32'h80; ex_pc_i = 32'h44;
      @(negedge clk);
      lit("irq ack", {31'd0, irq_ack_o}, 32'd1);
      lit("irq jump_addr", jump_addr_o, 32'h80);
      lit("irq hold_ex_mem", {30'd0, hold_ex_mem_o}, {30'd0, F});
      go(); irq_req_i = 1'b0;
      @(negedge clk);
      lit("irq epc", epc_o, 32'h44);
      go(); mem_wait_i = 1'b1; irq_req_i = 1'b1; ex_pc_i = 32'h48;
      @(negedge clk);
      lit("irq mw ack", {31'd0, irq_ack_o}, 32'd0);
      go(); mem_wait_i = 1'b0;
      go();
      @(negedge clk);
      lit("irq deferred ack", {31'd0, irq_ack_o}, 32'd1);
      go(); irq_req_i = 1'b0;
`endif

      go(); go();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port mem_wait_i, input, 1 bit: the data bus is not ready, so the MEM stage cannot advance.
REQ-004 SHALL have port ex_stall_i, input, 1 bit: a multi-cycle EX unit (divider) is busy.
REQ-005 SHALL have port load_use_i, input, 1 bit: ID has a load-use hazard against EX.
REQ-006 SHALL have ports jump_req_i (input, 1 bit) and jump_addr_i (input, `inst_addr_bus): EX branch mispredict and its target.
REQ-007 SHALL have ports hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o and hold_mem_wb_o, each output `holdpip_bus`: per-stage hold command.
REQ-008 SHALL have ports jump_en_o (output, 1 bit) and jump_addr_o (output, `inst_addr_bus): PC redirect.
REQ-009 SHALL, under PIPE_CTRL_IRQ_EN only, have ports irq_req_i (in, 1), mtvec_i (in, `inst_addr_bus), ex_pc_i (in, `inst_addr_bus), irq_ack_o (out, 1) and epc_o (out, `inst_addr_bus).

Function
REQ-010 SHALL encode hold commands as `hold_none=2'b00, `hold_wait=2'b01, `hold_flush=2'b10; unlisted stages default to `hold_none.
REQ-011 SHALL produce hold outputs combinationally from the current state and inputs (zero-cycle latency); the state, the pending jump and epc are registered.
REQ-012 SHALL use states RUN, MEMWAIT and FLUSH2.
REQ-013 SHALL apply priority: mem_wait_i > pending/new jump > irq (if enabled) > ex_stall_i > load_use_i.
REQ-014 mem_wait_i=1: pc, if_id, id_ex and ex_mem SHALL be `hold_wait; mem_wb SHALL be `hold_flush; next state SHALL be MEMWAIT.
REQ-015 jump_req_i during mem_wait_i SHALL latch jump_addr_i into a pending register; the latest request SHALL overwrite; no redirect while mem_wait_i=1.
REQ-016 Jump taken (new, or pending when mem_wait_i falls): jump_en_o=1 for exactly one cycle with jump_addr_o = target; if_id and id_ex SHALL be `hold_flush; pending SHALL clear; next state SHALL be FLUSH2.
REQ-017 FLUSH2 SHALL hold if_id at `hold_flush for one cycle to discard the stale synchronous-ROM fetch, then return to RUN; mem_wait_i in FLUSH2 SHALL take precedence and retain FLUSH2.
REQ-018 ex_stall_i=1: pc, if_id and id_ex SHALL be `hold_wait; ex_mem SHALL be `hold_flush.
REQ-019 load_use_i=1: pc and if_id SHALL be `hold_wait; id_ex SHALL be `hold_flush.
REQ-020 jump_req_i together with ex_stall_i or load_use_i SHALL let the jump win; the stall request SHALL be ignored that cycle.
REQ-021 With no request in RUN or MEMWAIT, all holds SHALL be `hold_none and the state SHALL return to RUN.

Reset
REQ-022 While rst=1, all hold outputs SHALL be `hold_flush and jump_en_o=0.
REQ-023 While rst=1, irq_ack_o SHALL be 0, the state SHALL be RUN, the pending jump SHALL be cleared, and jump_addr_o and epc_o SHALL be 0.
REQ-024 Reset asserted mid-MEMWAIT or mid-FLUSH2 SHALL discard the pending jump.

Configuration
REQ-025 With macro PIPE_CTRL_IRQ_EN defined, interrupt entry SHALL be accepted only when irq_req_i=1 in RUN with no mem_wait_i and no jump.
REQ-026 Interrupt entry SHALL give jump_en_o=1, jump_addr_o=mtvec_i, irq_ack_o=1 and epc_o<=ex_pc_i for one cycle, flush if_id, id_ex and ex_mem, and go to FLUSH2.
REQ-027 Without PIPE_CTRL_IRQ_EN, the irq ports and logic SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-028 The hold encodings, `holdpip_bus, `inst_addr_bus and the state encodings SHALL live in define.v.
REQ-029 The block SHALL be a single module with no sub-module; the pending-jump register SHALL be inline.

Verification
REQ-030 load_use_i=1 for 1 cycle -> hold_pc/if_id=`hold_wait, hold_id_ex=`hold_flush that cycle, all `hold_none the next.
REQ-031 jump_req_i=1, addr=0x0000_0100 -> jump_en_o=1 and addr 0x100 one cycle; if_id flushed 2 cycles, id_ex flushed 1 cycle.
REQ-032 mem_wait_i high 3 cycles, jump_req_i pulsed in cycle 2 (0x200) -> waits/mem_wb flush 3 cycles; jump_en_o=1 with 0x200 in cycle 4.
REQ-033 ex_stall_i and load_use_i together -> ex_stall response (ex_mem flush, id_ex wait); ex_stall_i with jump_req_i -> jump wins.
REQ-034 rst asserted in FLUSH2 with a pending jump -> all holds `hold_flush; after release, no jump_en_o pulse.
REQ-035 (IRQ_EN) irq_req_i=1, mtvec_i=0x80, ex_pc_i=0x44 -> irq_ack_o=1, jump to 0x80, epc_o=0x44; irq during mem_wait_i deferred.
